psa_lane_accum: RTL and testbench
=================================

# psa_lane_accum

Lane-wise accumulator that sits directly downstream of the 16-bit partitioned sub-word adder (PSA). It consumes the PSA's `Sum`/`Error` output stream and keeps one signed saturating accumulator per 4-bit lane. On request it performs a multi-cycle horizontal reduction of the lanes into a 16-bit sign-extended scalar. It also counts PSA overflow events. Used for PADDSB-chain statistics and for the multi-cycle reduction path.

## Interface
- `LANE_W`, 4, width of one PSA lane (fixed; the PSA is 4 x 4-bit)
- `ACC_W`, 8, signed width of each lane accumulator
- `CNT_W`, 8, width of the PSA error counter
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `clear`  in  1  synchronous clear, highest priority
- `in_valid`  in  1  PSA word valid
- `in_ready`  out  1  block can accept a word
- `in_sum`  in  16  PSA `Sum`; lane i = `in_sum[4i+3:4i]`, signed
- `in_error`  in  1  PSA `Error` flag for this word
- `red_req`  in  1  start a horizontal reduction
- `red_busy`  out  1  reduction in progress
- `red_done`  out  1  one-cycle pulse, `red_result` valid
- `red_result`  out  16  signed lane sum, sign-extended
- `acc_ovf`  out  1  sticky: some lane accumulator saturated
- `err_cnt`  out  CNT_W  count of accepted words with `in_error=1`
- `lane_acc`  out  4*ACC_W  lane accumulators, lane i at `[ACC_W*i +: ACC_W]`

## Operation
- States: IDLE, REDUCE, DONE.
- Reset (`rst_n=0`): state IDLE, all lane accumulators 0, `err_cnt=0`, `acc_ovf=0`, `red_result=0`, `red_done=0`, `red_busy=0`, `in_ready=1`.
- IDLE:
  - `in_ready=1`.
  - A word is accepted when `in_valid & in_ready`.
  - On acceptance, each lane computes `acc_i <= sat(acc_i + sext(lane_i))` at ACC_W-bit signed bounds [-128, 127].
  - Any lane that clips sets `acc_ovf`.
  - If `in_error=1`, `err_cnt` increments; it saturates at all-ones.
- `red_req` in IDLE moves the block to REDUCE, with lane index 0 and reduction sum 0.
  - If a word is accepted in the same cycle, that word is included: the accumulate happens at that edge, and REDUCE reads the updated registers.
- REDUCE:
  - `in_ready=0`, `red_busy=1`.
  - One lane per cycle, index 0 to 3: `red_sum += sext16(acc_idx)`. The range is [-512, 508], so no overflow occurs.
  - After lane 3, the block registers `red_result` and moves to DONE.
- DONE:
  - `red_done=1` for exactly one cycle, `red_busy=0`, `in_ready=0`.
  - The block then returns to IDLE.
- `red_result` holds its value until the next reduction completes, or until `clear`.
- `red_req` outside IDLE is ignored; it is not queued.
- Lane accumulators are not modified by a reduction.
- `clear`, in any state:
  - Zeros the accumulators, `err_cnt`, `acc_ovf` and `red_result`.
  - Forces IDLE and suppresses `red_done`.
  - `clear` takes priority over a same-cycle accept or `red_req`.
- `rst_n` asserted mid-REDUCE aborts immediately to reset values. No `red_done` is produced.

## Timing
- Accumulate latency is 1 cycle. A word accepted at edge N is visible on `lane_acc` after edge N.
- Reduction: `red_req` is sampled at edge N. `red_busy` is high in cycles N+1 to N+4. `red_done` and the new `red_result` are valid in cycle N+5. Back in IDLE at N+6.
- Throughput in IDLE is one word per cycle. Zero words are accepted during REDUCE/DONE (5 cycles). The upstream PSA stage must hold `in_valid`/`in_sum` until `in_ready`.
- `in_ready` and `red_busy` are combinational decodes of the registered state only. They never depend on inputs.
- All outputs are registered or state-decoded. There is no input-to-output combinational path.

## Structure
- Shared package `psa_pkg`:
  - State enum `psa_acc_state_t` (IDLE, REDUCE, DONE).
  - `PSA_LANES=4` and `PSA_LANE_W=4`.
  - Function `psa_lane(word, i)` that extracts a signed lane.
- One sub-module: `psa_sat_add`.
  - Parameterised signed saturating adder: ACC_W accumulator + LANE_W sign-extended lane, producing a sum and a `clip` flag.
  - Instantiated 4 times, one per lane.
- The reduction adder, index counter and FSM live in the top module.

## Test plan
- After reset: all outputs at reset values and `in_ready=1`. Accept `16'h7F81` once (lanes 1, -8, -1, 7), then `red_req`. Expect `lane_acc` lanes [1, -8, -1, 7], `red_busy` high for 4 cycles, `red_done` pulse at N+5, `red_result=16'hFFFF`.
- Saturation: accept `16'h0007` 19 times. Lane 0 reaches 126 after 18 words, then 127 after the 19th with `acc_ovf=1`. A following `16'h0008` (-8) gives 119, and `acc_ovf` stays 1.
- Error count: accept 300 words with `in_error=1` and `CNT_W=8`. Expect `err_cnt=8'hFF`, no wrap.
- Simultaneous events: in the same cycle assert `in_valid` with `16'h1111` and `red_req` on a cleared block. Expect `red_result=16'h0004`. `in_valid` held during REDUCE/DONE is stalled (`in_ready=0`) and accepted at N+6.
- `clear` and `rst_n`: `clear` at N+2 of a reduction gives IDLE at N+3, all accumulators 0, and no `red_done`. `rst_n` low at N+3 asynchronously zeros all outputs, and no `red_done` follows.
- Negative extreme: 20 words of `16'h8888`. Every lane saturates at -128, and reduction gives `red_result=16'hFE00` (-512).

Source files
------------

// File: rtl/psa_pkg.sv
// -----------------------------------------------------------------------------
// psa_pkg
// Shared definitions for blocks that sit on the 16-bit partitioned sub-word
// adder (PSA) output stream.
//   psa_acc_state_t : lane accumulator control states (IDLE, REDUCE, DONE)
//   PSA_LANES       : number of lanes in a PSA word
//   PSA_LANE_W      : width of one PSA lane
//   psa_lane()      : extracts lane i of a PSA word as a signed value
// -----------------------------------------------------------------------------
package psa_pkg;

   localparam int PSA_LANES  = 4;
   localparam int PSA_LANE_W = 4;
   localparam int PSA_WORD_W = PSA_LANES * PSA_LANE_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      DONE   = 2'd2
   } psa_acc_state_t;

   // Shift-then-truncate keeps the index arithmetic free of part-select
   // width mismatches for any caller-supplied index.
   function automatic logic signed [PSA_LANE_W-1:0] psa_lane(
      input logic [PSA_WORD_W-1:0] word,
      input int unsigned           i
   );
      logic [PSA_WORD_W-1:0] shifted;
      shifted = word >> (i * PSA_LANE_W);
      return shifted[PSA_LANE_W-1:0];
   endfunction

endpackage

// File: rtl/psa_sat_add.sv
// -----------------------------------------------------------------------------
// psa_sat_add
// Signed saturating adder: an ACC_W-bit accumulator plus a sign-extended
// LANE_W-bit lane value, clipped to the ACC_W-bit signed range.
//   acc  in  ACC_W   current accumulator value (signed)
//   lane in  LANE_W  lane value to add (signed)
//   sum  out ACC_W   saturated result
//   clip out 1       result was clipped to the positive or negative bound
// Purely combinational; the caller owns the register.
// -----------------------------------------------------------------------------
module psa_sat_add #(
   parameter int ACC_W  = 8,
   parameter int LANE_W = 4
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [LANE_W-1:0] lane,
   output logic [ACC_W-1:0]  sum,
   output logic              clip
);

   // One guard bit is enough: |lane| never exceeds |acc| range when
   // LANE_W <= ACC_W, so the true sum always fits in ACC_W+1 bits.
   logic [ACC_W:0] wide;

   assign wide = {acc[ACC_W-1], acc}
               + {{(ACC_W + 1 - LANE_W){lane[LANE_W-1]}}, lane};

   // The two top bits of the widened sum disagree exactly when the result
   // left the ACC_W-bit signed range; the guard bit gives the direction.
   assign clip = wide[ACC_W] ^ wide[ACC_W-1];

   assign sum = !clip       ? wide[ACC_W-1:0]
              : wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}   // most negative
              :               {1'b0, {(ACC_W-1){1'b1}}};  // most positive

endmodule

// File: rtl/psa_lane_accum.sv
// -----------------------------------------------------------------------------
// psa_lane_accum
// Lane-wise signed saturating accumulator fed by the PSA Sum/Error stream,
// with a multi-cycle horizontal reduction of the lanes into a 16-bit scalar
// and a saturating count of PSA error words.
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   clear        synchronous clear, wins over everything else
//   in_valid     PSA word valid          in_ready   word can be accepted
//   in_sum       PSA Sum (4 x 4-bit)     in_error   PSA Error for the word
//   red_req      start a reduction       red_busy   reduction in progress
//   red_done     one-cycle result pulse  red_result signed lane sum (16-bit)
//   acc_ovf      sticky lane saturation  err_cnt    saturating error count
//   lane_acc     lane accumulators, lane i at [ACC_W*i +: ACC_W]
// Reduction timing: red_req sampled at edge N -> red_busy in cycles N+1..N+4,
// red_done/red_result in cycle N+5, accepting again in cycle N+6.
// -----------------------------------------------------------------------------
module psa_lane_accum
   import psa_pkg::*;
#(
   parameter int LANE_W = 4,
   parameter int ACC_W  = 8,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [15:0]            in_sum,
   input  logic                   in_error,
   input  logic                   red_req,
   output logic                   red_busy,
   output logic                   red_done,
   output logic [15:0]            red_result,
   output logic                   acc_ovf,
   output logic [CNT_W-1:0]       err_cnt,
   output logic [4*ACC_W-1:0]     lane_acc
);

   localparam int RES_W = 16;

   psa_acc_state_t    state;
   logic [1:0]        idx;
   logic [RES_W-1:0]  red_sum;
   logic [ACC_W-1:0]  acc_q   [PSA_LANES];
   logic [ACC_W-1:0]  sat_sum [PSA_LANES];
   logic [PSA_LANES-1:0] clip;
   logic              accept;
   logic [ACC_W-1:0]  cur_acc;
   logic [RES_W-1:0]  cur_ext;

   // Handshake outputs decode the registered state only, so no input can
   // reach an output combinationally.
   assign in_ready = (state == IDLE);
   assign red_busy = (state == REDUCE);
   assign red_done = (state == DONE);
   assign accept   = in_valid & in_ready;

   // Lane currently being folded into the reduction sum, sign-extended.
   assign cur_acc = acc_q[idx];
   assign cur_ext = {{(RES_W - ACC_W){cur_acc[ACC_W-1]}}, cur_acc};

   for (genvar g = 0; g < PSA_LANES; g++) begin : g_lane
      psa_sat_add #(
         .ACC_W  (ACC_W),
         .LANE_W (LANE_W)
      ) u_sat_add (
         .acc  (acc_q[g]),
         .lane (psa_lane(in_sum, g)),
         .sum  (sat_sum[g]),
         .clip (clip[g])
      );
      assign lane_acc[ACC_W*g +: ACC_W] = acc_q[g];
   end

   // NOTE: every register here updates with <= so all right-hand sides see
   // pre-edge values; the reduction therefore reads accumulators that an
   // accept at the same edge as red_req has already updated one edge earlier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         red_sum    <= '0;
         red_result <= '0;
         acc_ovf    <= 1'b0;
         err_cnt    <= '0;
         // NOTE: the accumulator array is only four words of flops, not a RAM,
         // so it is reset element by element like any other state.
         for (int i = 0; i < PSA_LANES; i++) begin
            acc_q[i] <= '0;
         end
      end else if (clear) begin
         state      <= IDLE;
         idx        <= '0;
         red_sum    <= '0;
         red_result <= '0;
         acc_ovf    <= 1'b0;
         err_cnt    <= '0;
         for (int i = 0; i < PSA_LANES; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         // Accept only happens in IDLE (in_ready), independent of red_req.
         if (accept) begin
            for (int i = 0; i < PSA_LANES; i++) begin
               acc_q[i] <= sat_sum[i];
            end
            if (|clip) begin
               acc_ovf <= 1'b1;
            end
            if (in_error && (err_cnt != {CNT_W{1'b1}})) begin
               err_cnt <= err_cnt + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (red_req) begin
                  state   <= REDUCE;
                  idx     <= '0;
                  red_sum <= '0;
               end
            end
            REDUCE: begin
               // Range is [-512, 508]; 16 bits never overflow.
               red_sum <= red_sum + cur_ext;
               idx     <= idx + 2'd1;
               if (idx == 2'd3) begin
                  red_result <= red_sum + cur_ext;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psa_lane_accum.sv
// -----------------------------------------------------------------------------
// tb_psa_lane_accum
// Directed-vector bench for psa_lane_accum. Expected reduction results and the
// edge at which red_done must appear are queued when a reduction is started;
// a negedge monitor pops and compares whenever red_done is seen. State
// snapshots (lane_acc, err_cnt, flags) are compared directly after edges.
// -----------------------------------------------------------------------------
module tb_psa_lane_accum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_sum = '0;
   logic        in_error = 1'b0;
   logic        red_req = 1'b0;
   logic        red_busy;
   logic        red_done;
   logic [15:0] red_result;
   logic        acc_ovf;
   logic [7:0]  err_cnt;
   logic [31:0] lane_acc;

   typedef struct {
      logic [15:0] result;
      int          done_edge;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   edge_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   psa_lane_accum dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_error   (in_error),
      .red_req    (red_req),
      .red_busy   (red_busy),
      .red_done   (red_done),
      .red_result (red_result),
      .acc_ovf    (acc_ovf),
      .err_cnt    (err_cnt),
      .lane_acc   (lane_acc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] word, input logic err);
      in_valid = 1'b1;
      in_sum   = word;
      in_error = err;
      tick();
      in_valid = 1'b0;
      in_error = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Returns after edge N (the edge that samples red_req).
   task automatic start_red(input logic [15:0] exp_result, input bit expect_done, output int n);
      red_req = 1'b1;
      n = edge_cnt + 1;
      if (expect_done) sb_q.push_back('{exp_result, n + 4});
      tick();
      red_req = 1'b0;
   endtask

   // Monitor: every red_done must match a queued expectation.
   always @(negedge clk) begin
      if (red_done === 1'b1) begin
         check("red_done_expected", {31'd0, sb_q.size() > 0}, 32'd1);
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("red_result", {16'd0, red_result}, {16'd0, e.result});
            check("red_done_edge", edge_cnt, e.done_edge);
         end
      end
   end

   initial begin
      int n;

      // Reset values
      #2;
      check("rst_lane_acc", lane_acc, 32'h0);
      check("rst_err_cnt", {24'd0, err_cnt}, 32'h0);
      check("rst_flags", {28'd0, acc_ovf, red_done, red_busy, in_ready}, 32'b0001);
      check("rst_red_result", {16'd0, red_result}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single word then reduction: lanes [1, -8, -1, 7], sum -1
      send(16'h7F81, 1'b0);
      check("t1_lane_acc", lane_acc, 32'h07FF_F801);
      start_red(16'hFFFF, 1'b1, n);
      check("t1_busy_n1", {30'd0, red_busy, in_ready}, 32'b10);
      for (int k = 2; k <= 4; k++) begin
         tick();
         check("t1_busy", {30'd0, red_busy, in_ready}, 32'b10);
      end
      tick();
      check("t1_done_cycle", {29'd0, red_done, red_busy, in_ready}, 32'b100);
      tick();
      check("t1_back_idle", {29'd0, red_done, red_busy, in_ready}, 32'b001);
      check("t1_result_hold", {16'd0, red_result}, 32'h0000_FFFF);
      check("t1_lane_acc_kept", lane_acc, 32'h07FF_F801);

      // Positive saturation on lane 0
      do_clear();
      check("clr_red_result", {16'd0, red_result}, 32'h0);
      for (int k = 0; k < 18; k++) send(16'h0007, 1'b0);
      check("sat_18", lane_acc, 32'h0000_007E);
      check("sat_18_ovf", {31'd0, acc_ovf}, 32'd0);
      send(16'h0007, 1'b0);
      check("sat_19", lane_acc, 32'h0000_007F);
      check("sat_19_ovf", {31'd0, acc_ovf}, 32'd1);
      send(16'h0008, 1'b0);
      check("sat_minus8", lane_acc, 32'h0000_0077);
      check("sat_ovf_sticky", {31'd0, acc_ovf}, 32'd1);

      // Error counter saturation
      do_clear();
      for (int k = 0; k < 300; k++) send(16'h0000, 1'b1);
      check("err_cnt_sat", {24'd0, err_cnt}, 32'h0000_00FF);
      check("err_lane_acc", lane_acc, 32'h0);
      check("err_ovf", {31'd0, acc_ovf}, 32'd0);

      // Accept and red_req in the same cycle; next word stalls until N+6
      do_clear();
      in_valid = 1'b1;
      in_sum   = 16'h1111;
      start_red(16'h0004, 1'b1, n);
      in_sum = 16'h2222;
      check("sim_acc_n", lane_acc, 32'h0101_0101);
      check("sim_ready_n", {31'd0, in_ready}, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("sim_stall_acc", lane_acc, 32'h0101_0101);
         check("sim_stall_ready", {31'd0, in_ready}, 32'd0);
      end
      tick();
      check("sim_ready_n5", {31'd0, in_ready}, 32'd1);
      check("sim_acc_n5", lane_acc, 32'h0101_0101);
      tick();
      in_valid = 1'b0;
      check("sim_acc_n6", lane_acc, 32'h0303_0303);

      // clear at N+2 aborts the reduction, no red_done
      send(16'h1111, 1'b1);
      start_red(16'h0000, 1'b0, n);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_mid_flags", {30'd0, red_busy, in_ready}, 32'b01);
      check("clr_mid_acc", lane_acc, 32'h0);
      check("clr_mid_cnt", {24'd0, err_cnt}, 32'h0);
      check("clr_mid_result", {16'd0, red_result}, 32'h0);
      for (int k = 0; k < 6; k++) tick();

      // Build non-zero state, then async reset at N+3 of a reduction
      for (int k = 0; k < 17; k++) send(16'h0008, 1'b0);
      send(16'h1111, 1'b1);
      check("pre_rst_acc", lane_acc, 32'h0101_0181);
      start_red(16'hFF84, 1'b1, n);
      for (int k = 0; k < 5; k++) tick();
      check("pre_rst_result", {16'd0, red_result}, 32'h0000_FF84);
      start_red(16'h0000, 1'b0, n);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("arst_acc", lane_acc, 32'h0);
      check("arst_cnt_ovf", {23'd0, acc_ovf, err_cnt}, 32'h0);
      check("arst_result", {16'd0, red_result}, 32'h0);
      check("arst_flags", {29'd0, red_done, red_busy, in_ready}, 32'b001);
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) tick();

      // Negative extreme: every lane pinned at -128, reduction -512
      for (int k = 0; k < 20; k++) send(16'h8888, 1'b0);
      check("neg_acc", lane_acc, 32'h8080_8080);
      check("neg_ovf", {31'd0, acc_ovf}, 32'd1);
      start_red(16'hFE00, 1'b1, n);
      for (int k = 0; k < 6; k++) tick();

      check("sb_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
